// File: rtl/decode_pkg.sv
// Shared decode definitions: widths, RV64 base opcodes, immediate formats,
// the registered payload handed to execute and the opcode classifier.
package decode_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned STALL_W  = 16;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  // Registered payload presented to execute.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic [XLEN-1:0]   imm;
    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic              illegal;
  } decode_t;

  // Per-opcode properties derived from the major opcode alone.
  typedef struct packed {
    imm_fmt_e fmt;
    logic     legal;
    logic     writes_rd;
    logic     uses_rs1;
    logic     uses_rs2;
  } op_class_t;

  // Classify a major opcode; unknown opcodes come back illegal with no imm.
  function automatic op_class_t classify(input logic [OPC_W-1:0] opcode);
    op_class_t c;
    c     = '0;
    c.fmt = IMM_NONE;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        c.fmt       = IMM_I;
        c.legal     = 1'b1;
        c.writes_rd = 1'b1;
        c.uses_rs1  = 1'b1;
      end
      OPC_AUIPC, OPC_LUI: begin
        c.fmt       = IMM_U;
        c.legal     = 1'b1;
        c.writes_rd = 1'b1;
      end
      OPC_STORE: begin
        c.fmt      = IMM_S;
        c.legal    = 1'b1;
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        c.legal     = 1'b1;
        c.writes_rd = 1'b1;
        c.uses_rs1  = 1'b1;
        c.uses_rs2  = 1'b1;
      end
      OPC_BRANCH: begin
        c.fmt      = IMM_B;
        c.legal    = 1'b1;
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OPC_JAL: begin
        c.fmt       = IMM_J;
        c.legal     = 1'b1;
        c.writes_rd = 1'b1;
      end
      default: c.fmt = IMM_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction: I/S/B/U/J formats sign-extended to XLEN.
module imm_gen
  import decode_pkg::*;
(
  input  logic [ILEN-1:0] instr,
  input  imm_fmt_e        format,
  output logic [XLEN-1:0] imm
);

  // Opcode bits never contribute to an immediate.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[6:0];

  // Assemble the immediate for the selected format; B and J are halfword aligned.
  always_comb begin
    imm = '0;
    case (format)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV64 decode stage: one-entry output register to execute, register scoreboard
// for RAW hazards and a saturating stall counter.
// Optional feature: define DECODE_WB_BYPASS_EN to let a writeback retiring in
// the same cycle release a hazard immediately instead of one cycle later.
module decode_stage
  import decode_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [ILEN-1:0]    in_instr,
  output logic               in_ready,
  output logic [REG_AW-1:0]  rs1,
  output logic [REG_AW-1:0]  rs2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  out_rd,
  output logic               out_reg_write,
  output logic [XLEN-1:0]    out_imm,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [F3_W-1:0]    out_funct3,
  output logic [F7_W-1:0]    out_funct7,
  output logic               out_illegal,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic               flush,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_next;
  decode_t             out_q;
  decode_t             dec_c;
  op_class_t           cls;
  logic [XLEN-1:0]     dec_imm;
  logic [NUM_REGS-1:0] scoreboard;
  logic [NUM_REGS-1:0] scoreboard_next;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] pend_view;
  logic                hazard;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                accept;
  logic                issue;

  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];

  // Opcode classification of the offered instruction.
  always_comb begin
    cls = classify(in_instr[6:0]);
  end

  imm_gen u_imm_gen (
    .instr  (in_instr),
    .format (cls.fmt),
    .imm    (dec_imm)
  );

  // Decoded fields that load into the output register on accept.
  always_comb begin
    dec_c           = '0;
    dec_c.rd        = in_instr[11:7];
    dec_c.reg_write = cls.legal && cls.writes_rd && (in_instr[11:7] != '0);
    dec_c.imm       = cls.legal ? dec_imm : '0;
    dec_c.opcode    = in_instr[6:0];
    dec_c.funct3    = in_instr[14:12];
    dec_c.funct7    = in_instr[31:25];
    dec_c.illegal   = !cls.legal;
  end

  // Scoreboard set/clear vectors; an instruction issues when execute takes it.
  always_comb begin
    issue   = out_valid && out_ready && !flush;
    clr_vec = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
    set_vec = (issue && out_q.reg_write) ? (NUM_REGS'(1) << out_q.rd) : '0;
`ifdef DECODE_WB_BYPASS_EN
    pend_view = scoreboard & ~clr_vec;
`else
    pend_view = scoreboard;
`endif
  end

  // RAW hazard against pending writes and against the instruction held for execute.
  always_comb begin
    rs1_busy = (rs1 != '0) &&
               (pend_view[rs1] || (out_valid && out_q.reg_write && (out_q.rd == rs1)));
    rs2_busy = (rs2 != '0) &&
               (pend_view[rs2] || (out_valid && out_q.reg_write && (out_q.rd == rs2)));
    hazard   = (cls.uses_rs1 && rs1_busy) || (cls.uses_rs2 && rs2_busy);
    in_ready = (!out_valid || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  // Next-state logic for the output register occupancy.
  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: begin
        if (accept) state_next = S_FULL;
      end
      S_FULL: begin
        if (flush) state_next = S_EMPTY;
        else if (out_ready && !accept) state_next = S_EMPTY;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_EMPTY;
    else        state <= state_next;
  end

  assign out_valid = (state == S_FULL);

  // Output payload register; holds while execute back-pressures.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      out_q <= '0;
    else if (accept) out_q <= dec_c;
  end

  assign out_rd        = out_q.rd;
  assign out_reg_write = out_q.reg_write;
  assign out_imm       = out_q.imm;
  assign out_opcode    = out_q.opcode;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_illegal   = out_q.illegal;

  // Set wins over a same-cycle clear; x0 is never tracked.
  always_comb begin
    scoreboard_next    = (scoreboard & ~clr_vec) | set_vec;
    scoreboard_next[0] = 1'b0;
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scoreboard <= '0;
    else        scoreboard <= scoreboard_next;
  end

  // Saturating count of cycles an offered instruction was held by a hazard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [63:0] out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
    bit          u1;
    bit          u2;
  } dec_t;

  decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .rs1           (rs1),
    .rs2           (rs2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .out_imm       (out_imm),
    .out_opcode    (out_opcode),
    .out_funct3    (out_funct3),
    .out_funct7    (out_funct7),
    .out_illegal   (out_illegal),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  // Two's-complement interpretation of an n-bit field.
  function automatic longint sx(input longint unsigned val, input int bits);
    longint v;
    v = longint'(val);
    if (val >= (64'd1 << (bits - 1))) v = v - longint'(64'd1 << bits);
    return v;
  endfunction

  // Reference decode computed from the ISA encoding rules.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t   d;
    longint v;
    bit     wr;
    d.rd  = ins[11:7];
    d.opc = ins[6:0];
    d.f3  = ins[14:12];
    d.f7  = ins[31:25];
    d.ill = 1'b0;
    d.u1  = 0;
    d.u2  = 0;
    wr    = 0;
    v     = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67: begin
        v = sx(longint'(ins[31:20]), 12); wr = 1; d.u1 = 1;
      end
      7'h17, 7'h37: begin
        v = sx(longint'(ins[31:12]), 20) * 4096; wr = 1;
      end
      7'h23: begin
        v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); d.u1 = 1; d.u2 = 1;
      end
      7'h33, 7'h3B: begin
        wr = 1; d.u1 = 1; d.u2 = 1;
      end
      7'h63: begin
        v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
        d.u1 = 1; d.u2 = 1;
      end
      7'h6F: begin
        v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
               longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
        wr = 1;
      end
      default: d.ill = 1'b1;
    endcase
    d.imm = 64'(v);
    d.rw  = wr && (ins[11:7] != 5'd0);
    return d;
  endfunction

  // Is register r busy for an instruction offered against this model state?
  function automatic bit busy(input logic [4:0] r, input logic [31:0] pend, input bit wbv,
                              input logic [4:0] wbr, input bit hv, input dec_t h);
    bit p;
    if (r == 5'd0) return 0;
    p = pend[r];
    if (BYPASS && wbv && (wbr == r)) p = 0;
    return p || (hv && h.rw && (h.rd == r));
  endfunction

  function automatic logic [6:0] pick_opcode(input int k);
    case (k)
      0: return 7'h03;   1: return 7'h13;   2: return 7'h17;   3: return 7'h1B;
      4: return 7'h23;   5: return 7'h33;   6: return 7'h37;   7: return 7'h3B;
      8: return 7'h63;   9: return 7'h67;  10: return 7'h6F;
      default: return 7'($urandom);
    endcase
  endfunction

  // Idle inputs, pulse reset, return one step after a rising edge.
  task automatic apply_reset();
    in_valid = 0; in_instr = 0; out_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    reset = 0;
    @(posedge clk);
    #3 reset = 1;
    @(posedge clk);
    #1;
    exp_stall = 0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_rd !== 5'd0 || out_reg_write !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL reset_fields got rd=%0d rw=%0b ill=%0b exp=0", out_rd, out_reg_write, out_illegal); end
    checks++; if (out_imm !== 64'd0 || out_opcode !== 7'd0 || out_funct3 !== 3'd0 || out_funct7 !== 7'd0) begin errors++; $display("FAIL reset_imm_opc got imm=%h opc=%h exp=0", out_imm, out_opcode); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    checks++; if (dut.scoreboard !== 32'd0) begin errors++; $display("FAIL reset_scoreboard got=%h exp=0", dut.scoreboard); end
    reset = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    in_valid = 1; in_instr = 32'h00900613; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    checks++; if (out_rd !== 5'd12) begin errors++; $display("FAIL basic_rd got=%0d exp=12", out_rd); end
    checks++; if (out_imm !== 64'd9) begin errors++; $display("FAIL basic_imm got=%h exp=9", out_imm); end
    checks++; if (out_reg_write !== 1'b1 || out_illegal !== 1'b0) begin errors++; $display("FAIL basic_rw got rw=%0b ill=%0b exp rw=1 ill=0", out_reg_write, out_illegal); end
  endtask

  task automatic test_raw_stall();
    in_instr = 32'h009601B3;
    #1;
    checks++; if (rs1 !== 5'd12 || rs2 !== 5'd9) begin errors++; $display("FAIL raw_rs got rs1=%0d rs2=%0d exp 12/9", rs1, rs2); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_ready_held got=%0b exp=0", in_ready); end
    @(posedge clk); exp_stall++; #1;
    checks++; if (dut.scoreboard !== 32'h0000_1000) begin errors++; $display("FAIL raw_pending got=%h exp=00001000", dut.scoreboard); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_drained got=%0b exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_ready_stall%0d got=%0b exp=0", i, in_ready); end
      @(posedge clk); exp_stall++; #1;
      checks++; if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL raw_stall_cnt%0d got=%0d exp=%0d", i, stall_cnt, exp_stall); end
    end
    wb_valid = 1; wb_rd = 5'd12;
    #1;
    if (BYPASS) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready got=%0b exp=1", in_ready); end
      @(posedge clk); #1;
      wb_valid = 0;
    end else begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_ready got=%0b exp=0", in_ready); end
      @(posedge clk); exp_stall++; #1;
      wb_valid = 0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release_ready got=%0b exp=1", in_ready); end
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL raw_final_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_reg_write !== 1'b1) begin errors++; $display("FAIL raw_issue got v=%0b rd=%0d rw=%0b exp 1/3/1", out_valid, out_rd, out_reg_write); end
    checks++; if (out_opcode !== 7'h33 || out_funct3 !== 3'd0 || out_funct7 !== 7'd0) begin errors++; $display("FAIL raw_fields got opc=%h f3=%0d f7=%h exp 33/0/0", out_opcode, out_funct3, out_funct7); end
    checks++; if (dut.scoreboard !== 32'd0) begin errors++; $display("FAIL raw_cleared got=%h exp=0", dut.scoreboard); end
    in_valid = 0;
  endtask

  task automatic test_neg_imm();
    apply_reset();
    in_valid = 1; in_instr = 32'hFFF00093; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL neg_imm got=%h exp=ffffffffffffffff", out_imm); end
    checks++; if (out_rd !== 5'd1 || out_reg_write !== 1'b1) begin errors++; $display("FAIL neg_rd got rd=%0d rw=%0b exp 1/1", out_rd, out_reg_write); end
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_instr = 32'h00500293;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%0b exp=0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_opcode !== 7'h13) begin errors++; $display("FAIL bp_hold%0d got v=%0b rd=%0d imm=%h opc=%h", i, out_valid, out_rd, out_imm, out_opcode); end
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    checks++; if (out_rd !== 5'd5 || out_imm !== 64'd5) begin errors++; $display("FAIL bp_next got rd=%0d imm=%h exp 5/5", out_rd, out_imm); end
    checks++; if (dut.scoreboard !== 32'h0000_0002) begin errors++; $display("FAIL bp_scoreboard got=%h exp=00000002", dut.scoreboard); end
  endtask

  task automatic test_flush();
    in_valid = 1; in_instr = 32'h00700393; flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    checks++; if (dut.scoreboard !== 32'h0000_0002) begin errors++; $display("FAIL flush_scoreboard got=%h exp=00000002", dut.scoreboard); end
  endtask

  task automatic test_x0();
    apply_reset();
    in_valid = 1; in_instr = 32'h00000013; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || out_rd !== 5'd0) begin errors++; $display("FAIL x0_decode got v=%0b rw=%0b rd=%0d exp 1/0/0", out_valid, out_reg_write, out_rd); end
    @(posedge clk); #1;
    checks++; if (dut.scoreboard !== 32'd0) begin errors++; $display("FAIL x0_scoreboard got=%h exp=0", dut.scoreboard); end
  endtask

  task automatic test_illegal();
    in_valid = 1; in_instr = 32'hFFFFFFFF; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_imm !== 64'd0) begin errors++; $display("FAIL ill_decode got ill=%0b rw=%0b imm=%h exp 1/0/0", out_illegal, out_reg_write, out_imm); end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    in_valid = 1; in_instr = 32'h00900613; out_ready = 1;
    @(posedge clk); #1;
    in_instr = 32'h009601B3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 16'd2 || dut.scoreboard !== 32'h0000_1000) begin errors++; $display("FAIL mid_setup got stall=%0d sb=%h exp 2/00001000", stall_cnt, dut.scoreboard); end
    #2 reset = 0;
    #1;
    checks++; if (stall_cnt !== 16'd0 || dut.scoreboard !== 32'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_async got stall=%0d sb=%h v=%0b exp 0/0/0", stall_cnt, dut.scoreboard, out_valid); end
    in_valid = 0;
    reset = 1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0) begin errors++; $display("FAIL mid_no_replay got v=%0b rd=%0d exp 0/0", out_valid, out_rd); end
  endtask

  task automatic test_random();
    bit          m_valid;
    dec_t        m_q;
    dec_t        d;
    logic [31:0] m_pend;
    int          m_stall;
    bit          haz;
    bit          rdy;
    bit          acc;
    logic [31:0] ins;
    apply_reset();
    m_valid = 0; m_pend = 0; m_stall = 0; m_q = ref_decode(32'd0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ins        = $urandom;
      ins[6:0]   = pick_opcode($urandom_range(0, 11));
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      in_instr  = ins;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      d   = ref_decode(ins);
      haz = (d.u1 && busy(ins[19:15], m_pend, wb_valid, wb_rd, m_valid, m_q)) ||
            (d.u2 && busy(ins[24:20], m_pend, wb_valid, wb_rd, m_valid, m_q));
      rdy = (!m_valid || out_ready) && !haz && !flush;
      acc = in_valid && rdy;
      checks++; if (in_ready !== rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, rdy); end
      checks++; if (rs1 !== ins[19:15] || rs2 !== ins[24:20]) begin errors++; $display("FAIL rnd_rs cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, rs1, rs2, ins[19:15], ins[24:20]); end
      @(posedge clk);
      if (wb_valid) m_pend[wb_rd] = 1'b0;
      if (m_valid && out_ready && !flush && m_q.rw) m_pend[m_q.rd] = 1'b1;
      m_pend[0] = 1'b0;
      if (in_valid && haz && m_stall < 65535) m_stall++;
      if (flush) m_valid = 0;
      else if (acc) m_valid = 1;
      else if (out_ready) m_valid = 0;
      if (acc) m_q = d;
      #1;
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, m_valid); end
      checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stall); end
      checks++; if (dut.scoreboard !== m_pend) begin errors++; $display("FAIL rnd_scoreboard cyc=%0d got=%h exp=%h", cyc, dut.scoreboard, m_pend); end
      if (m_valid) begin
        checks++; if (out_rd !== m_q.rd || out_reg_write !== m_q.rw || out_illegal !== m_q.ill) begin errors++; $display("FAIL rnd_ctrl cyc=%0d got rd=%0d rw=%0b ill=%0b exp %0d/%0b/%0b", cyc, out_rd, out_reg_write, out_illegal, m_q.rd, m_q.rw, m_q.ill); end
        checks++; if (out_imm !== m_q.imm) begin errors++; $display("FAIL rnd_imm cyc=%0d got=%h exp=%h", cyc, out_imm, m_q.imm); end
        checks++; if (out_opcode !== m_q.opc || out_funct3 !== m_q.f3 || out_funct7 !== m_q.f7) begin errors++; $display("FAIL rnd_fields cyc=%0d got %h/%h/%h exp %h/%h/%h", cyc, out_opcode, out_funct3, out_funct7, m_q.opc, m_q.f3, m_q.f7); end
      end
    end
    in_valid = 0; wb_valid = 0; flush = 0;
  endtask

  initial begin
    reset = 0; in_valid = 0; in_instr = 0; out_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_raw_stall();
    test_neg_imm();
    test_backpressure();
    test_flush();
    test_x0();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
